// File: rtl/prng_pkg.sv
// Shared types and constants for the prng_lfsr_stream block.
package prng_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StValid
    } prng_state_e;

    localparam logic [7:0]  DefaultTaps8  = 8'hB8;
    localparam logic [15:0] DefaultTaps16 = 16'hB400;

    // Maximal-length Galois mask for the two widths we ship defaults for.
    function automatic logic [31:0] default_taps(int unsigned width);
        return (width == 16) ? 32'(DefaultTaps16) : 32'(DefaultTaps8);
    endfunction

endpackage

// File: rtl/prng_lfsr_stream_if.sv
// Valid/ready output stream carrying one random word per handshake.
interface prng_lfsr_stream_if #(
    parameter int unsigned OUT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;

    modport master (
        output out_valid,
        output out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out,
        output out_ready
    );
endinterface

// File: rtl/lfsr_galois_step.sv
// One right-shift Galois LFSR step; an all-zero state recovers to DEFAULT_SEED.
module lfsr_galois_step
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    always_comb begin
        if (state == '0) begin
            next_state = DEFAULT_SEED;
        end else begin
            next_state = (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/prng_lfsr_stream.sv
// Galois-LFSR PRNG emitting one word per STEPS advances over a valid/ready stream.
// Define PRNG_PERIOD_MON_EN to add the period_wrap / period_cnt monitor.
module prng_lfsr_stream
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(default_taps(WIDTH)),
    parameter int unsigned      OUT_W        = 8,
    parameter int unsigned      STEPS        = 1,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed,
    output logic               busy,
`ifdef PRNG_PERIOD_MON_EN
    output logic               period_wrap,
    output logic [31:0]        period_cnt,
`endif
    prng_lfsr_stream_if.master prng_out
);

    localparam logic [7:0] LastCnt = 8'(STEPS - 1);

    prng_state_e      fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] load_val;

    lfsr_galois_step #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_step (
        .state      (state_q),
        .next_state (step_next)
    );

    assign load_val = (seed == '0) ? DEFAULT_SEED : seed;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= StIdle;
            state_q <= DEFAULT_SEED;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = valid_q;
        // A seed load discards any pending word, even one being accepted this cycle.
        if (seed_load) begin
            state_d = load_val;
            fsm_d   = StIdle;
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (fsm_q)
                StIdle: begin
                    if (en) begin
                        fsm_d = StStep;
                        cnt_d = '0;
                    end
                end
                StStep: begin
                    state_d = step_next;
                    cnt_d   = cnt_q + 8'd1;
                    if (cnt_q == LastCnt) begin
                        out_d   = step_next[OUT_W-1:0];
                        valid_d = 1'b1;
                        fsm_d   = StValid;
                        cnt_d   = '0;
                    end
                end
                StValid: begin
                    if (prng_out.out_ready) begin
                        valid_d = 1'b0;
                        fsm_d   = en ? StStep : StIdle;
                    end
                end
                default: fsm_d = StIdle;
            endcase
        end
    end

    assign prng_out.out_valid = valid_q;
    assign prng_out.out       = out_q;
    assign busy               = (fsm_q != StIdle);

`ifdef PRNG_PERIOD_MON_EN
    logic [WIDTH-1:0] ref_seed_q;
    logic [31:0]      period_cnt_q;
    logic             period_wrap_q;

    // Wrap is flagged when the step about to be committed returns to the reference seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_seed_q    <= DEFAULT_SEED;
            period_cnt_q  <= '0;
            period_wrap_q <= 1'b0;
        end else if (seed_load) begin
            ref_seed_q    <= load_val;
            period_cnt_q  <= '0;
            period_wrap_q <= 1'b0;
        end else if (fsm_q == StStep) begin
            if (step_next == ref_seed_q) begin
                period_cnt_q  <= '0;
                period_wrap_q <= 1'b1;
            end else begin
                period_cnt_q  <= period_cnt_q + 32'd1;
                period_wrap_q <= 1'b0;
            end
        end else begin
            period_wrap_q <= 1'b0;
        end
    end

    assign period_wrap = period_wrap_q;
    assign period_cnt  = period_cnt_q;
`endif

endmodule

// File: tb/tb_prng_lfsr_stream.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks the DUTs.
module tb_prng_lfsr_stream;

    logic       clk;
    logic       rst;
    logic       en;
    logic       en3;
    logic       seed_load;
    logic [7:0] seed;
    logic       ready1;
    logic       ready3;
    logic       busy1;
    logic       busy3;
    logic       idle_chk1;
    int         exp_gap1;
    int         exp_gap3;
    int         n_vec;
    int         n_miss;
    logic [7:0] q1[$];
    logic [7:0] q3[$];

`ifdef PRNG_PERIOD_MON_EN
    logic        pw1, pw3;
    logic [31:0] pc1, pc3;
`endif

    prng_lfsr_stream_if #(.OUT_W(8)) if1 ();
    prng_lfsr_stream_if #(.OUT_W(8)) if3 ();

    assign if1.out_ready = ready1;
    assign if3.out_ready = ready3;

    prng_lfsr_stream #(
        .WIDTH(8), .TAPS(8'hB8), .OUT_W(8), .STEPS(1), .DEFAULT_SEED(8'h01)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy1),
`ifdef PRNG_PERIOD_MON_EN
        .period_wrap (pw1),
        .period_cnt  (pc1),
`endif
        .prng_out  (if1)
    );

    prng_lfsr_stream #(
        .WIDTH(8), .TAPS(8'hB8), .OUT_W(8), .STEPS(3), .DEFAULT_SEED(8'h01)
    ) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .en        (en3),
        .seed_load (seed_load),
        .seed      (seed),
        .busy      (busy3),
`ifdef PRNG_PERIOD_MON_EN
        .period_wrap (pw3),
        .period_cnt  (pc3),
`endif
        .prng_out  (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_step(input logic [7:0] s);
        if (s == 8'h00) return 8'h01;
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
    endtask

    task automatic drain1();
        while (q1.size() != 0) tick();
    endtask

    task automatic drain3();
        while (q3.size() != 0) tick();
    endtask

    // Monitor: every comparison happens here, on the falling edge.
    initial begin : monitor
        int         ncyc, last1, last3, lat1, lat3, wd1, wd3;
        logic       have1, have3, lat1_arm, lat3_arm, en_q, en3_q;
        logic       hold1_v, post_load, rst_done;
        logic [7:0] hold1, exp_w;
        ncyc = 0; last1 = 0; last3 = 0; lat1 = 0; lat3 = 0; wd1 = 0; wd3 = 0;
        have1 = 0; have3 = 0; lat1_arm = 0; lat3_arm = 0; en_q = 0; en3_q = 0;
        hold1_v = 0; post_load = 0; rst_done = 0; hold1 = '0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (rst) begin
                if (!rst_done) begin
                    chk("rst_valid1", 32'(if1.out_valid), 0);
                    chk("rst_busy1", 32'(busy1), 0);
                    chk("rst_out1", 32'(if1.out), 0);
                    chk("rst_valid3", 32'(if3.out_valid), 0);
                    chk("rst_busy3", 32'(busy3), 0);
                    chk("rst_out3", 32'(if3.out), 0);
                    rst_done = 1;
                end
                hold1_v = 0; post_load = 0; have1 = 0; have3 = 0;
                lat1_arm = 0; lat3_arm = 0; en_q = 0; en3_q = 0;
            end else begin
                if (post_load) begin
                    chk("load_valid1", 32'(if1.out_valid), 0);
                    chk("load_busy1", 32'(busy1), 0);
                    chk("load_valid3", 32'(if3.out_valid), 0);
                    chk("load_busy3", 32'(busy3), 0);
                end
                post_load = seed_load;
                if (idle_chk1) begin
                    chk("idle_busy1", 32'(busy1), 0);
                    chk("idle_valid1", 32'(if1.out_valid), 0);
                end
                if (hold1_v) begin
                    chk("stall_valid1", 32'(if1.out_valid), 1);
                    chk("stall_out1", 32'(if1.out), 32'(hold1));
                end
                hold1_v = if1.out_valid && !ready1 && !seed_load;
                hold1   = if1.out;

                if (lat1_arm) begin
                    lat1++;
                    if (if1.out_valid || lat1 > 20) begin
                        chk("latency1", 32'(lat1), 2);
                        lat1_arm = 0;
                    end
                end
                if (en && !en_q) begin lat1_arm = 1; lat1 = 0; end
                en_q = en;
                if (lat3_arm) begin
                    lat3++;
                    if (if3.out_valid || lat3 > 20) begin
                        chk("latency3", 32'(lat3), 4);
                        lat3_arm = 0;
                    end
                end
                if (en3 && !en3_q) begin lat3_arm = 1; lat3 = 0; end
                en3_q = en3;

                if (if1.out_valid && ready1 && !seed_load) begin
                    if (q1.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_word1: got %0h, expected no word", if1.out);
                    end else begin
                        exp_w = q1.pop_front();
                        chk("word1", 32'(if1.out), 32'(exp_w));
                        chk("nonzero1", 32'(if1.out != 8'h00), 1);
                        if (have1 && exp_gap1 != 0) chk("gap1", 32'(ncyc - last1), 32'(exp_gap1));
                        last1 = ncyc;
                        have1 = 1;
                    end
                    wd1 = 0;
                end else if (q1.size() != 0) begin
                    wd1++;
                    if (wd1 > 100) begin
                        n_vec++; n_miss++;
                        $display("FAIL timeout1: got no word in 100 cycles, expected %0h", q1[0]);
                        q1.delete();
                        wd1 = 0;
                    end
                end else begin
                    wd1 = 0;
                end

                if (if3.out_valid && ready3 && !seed_load) begin
                    if (q3.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_word3: got %0h, expected no word", if3.out);
                    end else begin
                        exp_w = q3.pop_front();
                        chk("word3", 32'(if3.out), 32'(exp_w));
                        if (have3 && exp_gap3 != 0) chk("gap3", 32'(ncyc - last3), 32'(exp_gap3));
                        last3 = ncyc;
                        have3 = 1;
                    end
                    wd3 = 0;
                end else if (q3.size() != 0) begin
                    wd3++;
                    if (wd3 > 100) begin
                        n_vec++; n_miss++;
                        $display("FAIL timeout3: got no word in 100 cycles, expected %0h", q3[0]);
                        q3.delete();
                        wd3 = 0;
                    end
                end else begin
                    wd3 = 0;
                end
                if (seed_load) begin have1 = 0; have3 = 0; end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish by 200000");
        $fatal(1);
    end

    initial begin : stimulus
        logic [7:0] m;
        n_vec = 0; n_miss = 0;
        rst = 1'b1; en = 1'b0; en3 = 1'b0; seed_load = 1'b0; seed = 8'h00;
        ready1 = 1'b0; ready3 = 1'b0; idle_chk1 = 1'b0; exp_gap1 = 0; exp_gap3 = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Back-to-back words from seed 01, one every two cycles.
        load(8'h01);
        exp_gap1 = 2;
        q1.push_back(8'hB8); q1.push_back(8'h5C); q1.push_back(8'h2E);
        q1.push_back(8'h17); q1.push_back(8'hB3);
        en = 1'b1; ready1 = 1'b1;
        drain1();

        // Stall: word must hold, sequence resumes without skipped steps.
        ready1 = 1'b0; exp_gap1 = 0;
        q1.push_back(8'hE1);
        repeat (12) tick();
        ready1 = 1'b1;
        q1.push_back(8'hC8); q1.push_back(8'h64);
        drain1();
        ready1 = 1'b0; en = 1'b0;

        // Zero seed falls back to 01; long run checked against the model.
        load(8'h00);
        exp_gap1 = 2;
        m = 8'h01;
        for (int i = 0; i < 600; i++) begin
            m = model_step(m);
            q1.push_back(m);
        end
        en = 1'b1; ready1 = 1'b1;
        drain1();

        // Seed load collides with an accept: word dropped, restart from 5C.
        ready1 = 1'b0; exp_gap1 = 0;
        tick();
        seed = 8'h5C; seed_load = 1'b1; ready1 = 1'b1;
        tick();
        seed_load = 1'b0;
        q1.push_back(8'h2E); q1.push_back(8'h17); q1.push_back(8'hB3);
        drain1();

        // Dropping en mid-step still delivers the word in flight, then idles.
        q1.push_back(8'hE1);
        en = 1'b0;
        drain1();
        tick();
        idle_chk1 = 1'b1;
        repeat (4) tick();
        idle_chk1 = 1'b0;
        ready1 = 1'b0;

        // Three steps per word.
        load(8'h01);
        exp_gap3 = 4;
        q3.push_back(8'h2E); q3.push_back(8'hE1); q3.push_back(8'h32);
        en3 = 1'b1; ready3 = 1'b1;
        drain3();
        ready3 = 1'b0; en3 = 1'b0;
        load(8'h01);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
